// File: rtl/branch_unit_pipelined.sv
// Branch unit for the execute stage: resolves conditional branches and jumps,
// computes link value and next fetch address, flags mispredictions and
// misaligned targets, and queues results in a small output buffer with
// valid/ready handshakes. Also keeps a saturating count of retired mispredicts.
module branch_unit_pipelined #(
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3,
  parameter int OUT_DEPTH     = 2,
  parameter int RVC           = 1,
  parameter int CNT_BITS      = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  input  logic [2:0]               operator_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [XLEN-1:0]          imm_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic                     is_compressed_instr_i,
  input  logic                     predict_valid_i,
  input  logic                     predict_taken_i,
  input  logic [XLEN-1:0]          predict_address_i,
  input  logic                     is_call_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic [XLEN-1:0]          result_o,
  output logic [XLEN-1:0]          target_o,
  output logic                     is_taken_o,
  output logic                     is_mispredict_o,
  output logic                     ras_push_o,
  output logic                     ex_valid_o,
  output logic [XLEN-1:0]          ex_tval_o,
  output logic [CNT_BITS-1:0]      mispredict_cnt_o
);

  // Operator encoding shared with the decoder.
  localparam logic [2:0] OP_EQ   = 3'd0;
  localparam logic [2:0] OP_NE   = 3'd1;
  localparam logic [2:0] OP_LTS  = 3'd2;
  localparam logic [2:0] OP_LTU  = 3'd3;
  localparam logic [2:0] OP_GES  = 3'd4;
  localparam logic [2:0] OP_GEU  = 3'd5;
  localparam logic [2:0] OP_JAL  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int OCC_W = $clog2(OUT_DEPTH) + 1;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          result;
    logic [XLEN-1:0]          target;
    logic                     taken;
    logic                     mispredict;
    logic                     ras_push;
    logic                     ex_valid;
    logic [XLEN-1:0]          ex_tval;
  } entry_t;

  // Resolution signals for the incoming instruction.
  logic            compressed_eff;
  logic [XLEN:0]   a_sext;
  logic [XLEN:0]   b_sext;
  logic            eq;
  logic            lt_signed;
  logic            lt_unsigned;
  logic            taken;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            ex_valid;
  logic            mispredict;
  entry_t          new_entry;

  // Buffer state.
  entry_t             mem_q [OUT_DEPTH];
  entry_t             mem_d [OUT_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic               push;
  logic               pop;
  entry_t             head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Compare operands, form addresses and classify the outcome of the incoming op.
  always_comb begin
    compressed_eff = (RVC != 0) && is_compressed_instr_i;
    a_sext         = {operand_a_i[XLEN-1], operand_a_i};
    b_sext         = {operand_b_i[XLEN-1], operand_b_i};
    eq             = (operand_a_i == operand_b_i);
    lt_signed      = $signed(a_sext) < $signed(b_sext);
    lt_unsigned    = operand_a_i < operand_b_i;

    taken = 1'b0;
    case (operator_i)
      OP_EQ:   taken = eq;
      OP_NE:   taken = !eq;
      OP_LTS:  taken = lt_signed;
      OP_LTU:  taken = lt_unsigned;
      OP_GES:  taken = !lt_signed;
      OP_GEU:  taken = !lt_unsigned;
      OP_JAL:  taken = 1'b1;
      OP_JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase

    next_pc = pc_i + (compressed_eff ? XLEN'(2) : XLEN'(4));
    base    = (operator_i == OP_JALR) ? operand_a_i : pc_i;
    target  = base + imm_i;
    if (operator_i == OP_JALR) begin
      target[0] = 1'b0;
    end

    if (RVC != 0) begin
      misaligned = target[0];
    end else begin
      misaligned = |target[1:0];
    end
    ex_valid = misaligned && taken;

    if (predict_valid_i) begin
      mispredict = (predict_taken_i != taken) ||
                   (predict_taken_i && (target != predict_address_i));
    end else begin
      mispredict = taken;
    end
    if (ex_valid) begin
      mispredict = 1'b0;
    end

    new_entry.trans_id   = trans_id_i;
    new_entry.result     = next_pc;
    new_entry.target     = taken ? target : next_pc;
    new_entry.taken      = taken;
    new_entry.mispredict = mispredict;
    new_entry.ras_push   = is_call_i;
    new_entry.ex_valid   = ex_valid;
    new_entry.ex_tval    = pc_i;
  end

  // Handshake decode: occupancy alone sets ready/valid, so there is no comb path from ready_i.
  always_comb begin
    ready_o = (count_q != OCC_W'(OUT_DEPTH));
    valid_o = (count_q != '0);
    push    = valid_i && ready_o && !flush_i;
    pop     = valid_o && ready_i;
    head    = mem_q[rd_ptr_q];
  end

  // Next buffer state: flush empties everything and drops the same-cycle input.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Mispredict counter: counts retired mispredicts, including a pop in a flush cycle, and saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (pop && head.mispredict && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  // Control state registers; reset empties the buffer and clears the counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset because outputs are masked while the buffer is empty.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // Drive the head entry, forced to zero whenever nothing valid is buffered.
  always_comb begin
    trans_id_o       = valid_o ? head.trans_id   : '0;
    result_o         = valid_o ? head.result     : '0;
    target_o         = valid_o ? head.target     : '0;
    is_taken_o       = valid_o && head.taken;
    is_mispredict_o  = valid_o && head.mispredict;
    ras_push_o       = valid_o && head.ras_push;
    ex_valid_o       = valid_o && head.ex_valid;
    ex_tval_o        = valid_o ? head.ex_tval    : '0;
    mispredict_cnt_o = cnt_q;
  end

endmodule
